// File: rtl/write_dispatch_fifo_pkg.sv
// rtl/write_dispatch_fifo_pkg.sv - shared constants for the write dispatch FIFO
package write_dispatch_fifo_pkg;

    // Width of a target select and the number of targets it can address.
    localparam int SEL_W       = 3;
    localparam int NUM_TARGETS = 8;

endpackage

// File: rtl/write_dispatch_fifo_if.sv
// rtl/write_dispatch_fifo_if.sv - producer/consumer bus of the write dispatch FIFO
// Ports (slave = FIFO side):
//   wr_valid/wr_ready/wr_sel/wr_data : write side, accepted when valid & ready
//   out_valid/out_ready/out_sel/out_data : head entry, drained when valid & ready
//   out_load : one-hot strobe on out_sel for each drained entry
//   level    : number of stored entries
import write_dispatch_fifo_pkg::*;

interface write_dispatch_fifo_if #(
    parameter int D_WIDTH = 16,
    parameter int DEPTH   = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                   wr_valid;
    logic                   wr_ready;
    logic [SEL_W-1:0]       wr_sel;
    logic [D_WIDTH-1:0]     wr_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [SEL_W-1:0]       out_sel;
    logic [D_WIDTH-1:0]     out_data;
    logic [NUM_TARGETS-1:0] out_load;
    logic [LVL_W-1:0]       level;

    modport master (
        output wr_valid, wr_sel, wr_data, out_ready,
        input  wr_ready, out_valid, out_sel, out_data, out_load, level
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data, out_ready,
        output wr_ready, out_valid, out_sel, out_data, out_load, level
    );
endinterface

// File: rtl/write_dispatch_fifo_dmux8way.sv
// rtl/write_dispatch_fifo_dmux8way.sv - 8-way demultiplexer (module dmux8way)
// Ports:
//   din  : D_WIDTH input value
//   sel  : selects which of the 8 output lanes carries din
//   dout : 8 lanes of D_WIDTH, all zero except lane sel
import write_dispatch_fifo_pkg::*;

module dmux8way #(
    parameter int D_WIDTH = 1
) (
    input  logic [D_WIDTH-1:0]             din,
    input  logic [SEL_W-1:0]               sel,
    output logic [NUM_TARGETS*D_WIDTH-1:0] dout
);
    always_comb begin
        dout = '0;
        dout[sel*D_WIDTH +: D_WIDTH] = din;
    end
endmodule

// File: rtl/write_dispatch_fifo.sv
// rtl/write_dispatch_fifo.sv - buffered write dispatch FIFO with one-hot load strobe
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset (clears pointers and level)
//   bus     : write_dispatch_fifo_if.slave (write side, head side, out_load, level)
// Optional macro WRITE_DISPATCH_BYPASS_EN: an empty FIFO forwards the incoming
// write combinationally to the head outputs; if taken the same cycle it is never stored.
import write_dispatch_fifo_pkg::*;

module write_dispatch_fifo #(
    parameter int D_WIDTH = 16,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    write_dispatch_fifo_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [D_WIDTH-1:0] data_q [DEPTH];
    logic [D_WIDTH-1:0] data_d [DEPTH];
    logic [SEL_W-1:0]   sel_q  [DEPTH];
    logic [SEL_W-1:0]   sel_d  [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic fire;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));

    // Depends only on registered level, never on out_ready.
    assign bus.wr_ready = ~full;
    assign bus.level    = level_q;

`ifdef WRITE_DISPATCH_BYPASS_EN
    assign bus.out_valid = ~empty | bus.wr_valid;
    assign bus.out_sel   = empty ? bus.wr_sel  : sel_q[rd_ptr_q];
    assign bus.out_data  = empty ? bus.wr_data : data_q[rd_ptr_q];
    // A write consumed straight through an empty FIFO is not stored.
    assign push = bus.wr_valid & ~full & ~(empty & bus.out_ready);
`else
    assign bus.out_valid = ~empty;
    assign bus.out_sel   = sel_q[rd_ptr_q];
    assign bus.out_data  = data_q[rd_ptr_q];
    assign push = bus.wr_valid & ~full;
`endif

    assign pop  = ~empty & bus.out_ready;
    assign fire = bus.out_valid & bus.out_ready;

    dmux8way #(
        .D_WIDTH(1)
    ) u_load_dmux (
        .din  (fire),
        .sel  (bus.out_sel),
        .dout (bus.out_load)
    );

    always_comb begin
        data_d   = data_q;
        sel_d    = sel_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            data_d[wr_ptr_q] = bus.wr_data;
            sel_d[wr_ptr_q]  = bus.wr_sel;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        sel_q  <= sel_d;
    end
endmodule

// File: tb/tb_write_dispatch_fifo.sv
// tb/tb_write_dispatch_fifo.sv - randomized self-checking bench for write_dispatch_fifo
module tb_write_dispatch_fifo;
    localparam int D_WIDTH = 16;
    localparam int DEPTH   = 4;
`ifdef WRITE_DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    write_dispatch_fifo_if #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) bus ();

    write_dispatch_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: queue of {sel, data} in acceptance order.
    logic [18:0] model_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, compare outputs, then advance the model at posedge.
    task automatic step(input logic rst_n, input logic wv, input logic [2:0] sel,
                        input logic [15:0] data, input logic rdy, input int exp_load);
        logic        exp_valid;
        logic [18:0] head;
        logic [7:0]  load;
        int          sz;
        @(negedge clk);
        reset_n      = rst_n;
        bus.wr_valid = wv;
        bus.wr_sel   = sel;
        bus.wr_data  = data;
        bus.out_ready = rdy;
        #1;
        sz        = model_q.size();
        exp_valid = (sz != 0) || (BYP && wv);
        head      = (sz != 0) ? model_q[0] : {sel, data};
        load      = (exp_valid && rdy) ? (8'h01 << head[18:16]) : 8'h00;
        check_val("level",    32'(bus.level), 32'(sz));
        check_val("wr_ready", 32'(bus.wr_ready), 32'(sz < DEPTH));
        check_val("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check_val("out_load", 32'(bus.out_load), 32'(load));
        if (exp_valid) begin
            check_val("out_sel",  32'(bus.out_sel), 32'(head[18:16]));
            check_val("out_data", 32'(bus.out_data), 32'(head[15:0]));
        end
        if (exp_load >= 0)
            check_val("load_const", 32'(bus.out_load), 32'(exp_load));
        @(posedge clk);
        if (!rst_n) begin
            model_q.delete();
        end else if (sz == 0) begin
            if (wv && !(BYP && rdy)) model_q.push_back({sel, data});
        end else begin
            if (rdy) void'(model_q.pop_front());
            if (wv && sz < DEPTH) model_q.push_back({sel, data});
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_sel = '0;
        bus.wr_data = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);

        // Reset, then a single write seen one cycle later.
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, -1);
        step(1'b1, 1'b1, 3'd3, 16'h00AB, 1'b0, 0);
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 0);

        // Fill to DEPTH, fifth write ignored, drain in order.
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, -1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 3'd3, 16'h1000 + 16'(i), 1'b0, -1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 8'h08);
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 0);

        // Level 2 with simultaneous accept and drain for 10 cycles.
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, -1);
        step(1'b1, 1'b1, 3'd1, 16'h2000, 1'b0, -1);
        step(1'b1, 1'b1, 3'd2, 16'h2001, 1'b0, -1);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 3'(i), 16'h2100 + 16'(i), 1'b1, -1);

        // Reset with entries stored; they must not re-emerge.
        step(1'b1, 1'b1, 3'd5, 16'h3000, 1'b0, -1);
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, -1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 0);

        // Empty buffer, write sel 7 with out_ready high.
        step(1'b1, 1'b1, 3'd7, 16'h1234, 1'b1, BYP ? 8'h80 : 8'h00);
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, BYP ? 8'h00 : 8'h80);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
                 3'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0) | (i >= 300 && $urandom_range(0, 1) == 1), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
